matmul_operand_loader: RTL and testbench
========================================

// Module: matmul_operand_loader
// PURPOSE
//  Upstream feeder for matmul. Accepts a valid/ready element stream, fills A
//  (R1xC1) then B (R2xC2) in row-major order, and drives the packed A/B operand
//  buses. It pulses matmul's cen for LATENCY cycles, then holds C via c_valid/c_ready.
//  One frame = R1*C1 + R2*C2 beats; s_last marks the final B beat.
// PARAMETERS
//  R1       2                 rows of A
//  C1       2                 cols of A; must equal R2 (elaboration $error otherwise)
//  R2       2                 rows of B
//  C2       2                 cols of B
//  W_A      8                 signed width of A elements
//  W_B      8                 signed width of B elements
//  W_IN     max(W_A,W_B)      stream data width; A uses s_data[W_A-1:0], B uses [W_B-1:0]
//  LATENCY  $clog2(C1)+1      matmul pipeline depth in cen-enabled cycles
// PORTS
//  clk        in   1                   clock, rising edge
//  rst        in   1                   async active-high reset
//  s_valid    in   1                   stream element valid
//  s_ready    out  1                   stream element ready
//  s_data     in   W_IN                element, signed two's complement
//  s_last     in   1                   final beat of frame (last B element)
//  A          out  [R1][C1][W_A]       operand A to matmul, registered
//  B          out  [R2][C2][W_B]       operand B to matmul, registered
//  cen        out  1                   matmul clock enable
//  c_valid    out  1                   matmul C valid and frozen
//  c_ready    in   1                   consumer has taken C
//  frame_err  out  1                   one-cycle pulse on framing error
// BEHAVIOUR
//  Reset (async, immediate): state=LOAD_A, idx=0, lat_cnt=0, A=0, B=0, cen=0,
//   c_valid=0, frame_err=0. s_ready=1 as soon as rst deasserts.
//  Beat = s_valid & s_ready at posedge clk. s_ready is decoded from state only,
//   never from s_valid.
//  LOAD_A: s_ready=1. Beat writes A[idx/C1][idx%C1]; idx++. After beat R1*C1:
//   idx=0, go to LOAD_B. s_last on any LOAD_A beat: pulse frame_err, idx=0,
//   stay in LOAD_A, partial data discarded (A regs may hold stale values).
//  LOAD_B: s_ready=1. Beat writes B[idx/C2][idx%C2].
//   - s_last before the final beat: frame_err, go to LOAD_A.
//   - Final beat with s_last: go to COMPUTE, lat_cnt=0.
//   - Final beat without s_last: frame_err, go to DRAIN.
//  DRAIN: s_ready=1. Beats are discarded; the s_last beat moves to LOAD_A.
//   cen stays 0.
//  COMPUTE: s_ready=0, cen=1 for exactly LATENCY consecutive cycles, then DONE.
//   A/B are stable throughout.
//  DONE: cen=0 (C frozen), c_valid=1, s_ready=0. On c_ready=1: next cycle
//   c_valid=0, go to LOAD_A, idx=0. c_valid never drops without c_ready.
//  Latency: the final B beat at edge N gives cen=1 in cycles N+1..N+LATENCY and
//   c_valid=1 from cycle N+LATENCY+1.
//  Gaps in s_valid are legal in every load state; idx holds.
//  A/B are written only on beats. They persist across DONE and into the next
//   frame until overwritten.
//  frame_err is registered, high one cycle per error event.
//  rst in any state (including mid-COMPUTE or DONE) aborts: outputs return to
//   reset values on the same cycle.
// TESTING
//  1 Stream 1,2,3,4,5,6,7,8 (s_last on 8th) -> A=[[1,2],[3,4]], B=[[5,6],[7,8]];
//    cen high exactly 2 cycles; c_valid; matmul C=[[19,22],[43,50]].
//  2 Signed: A all 0xFF, B all 0x80 -> C all +256; s_valid toggling every
//    other cycle gives the same result.
//  3 Hold c_ready=0 for 5 cycles in DONE -> c_valid, C, A, B stable; s_ready=0;
//    cen=0; c_ready=1 -> LOAD_A next cycle.
//  4 s_last on beat 3 -> frame_err pulse, idx reset; a following good frame
//    (test 1 data) yields C=[[19,22],[43,50]].
//  5 8 beats, no s_last -> frame_err, DRAIN; 3 more beats with s_last on the
//    3rd -> LOAD_A, cen never asserted.
//  6 rst asserted in the 1st COMPUTE cycle -> cen=0, A=B=0, c_valid=0
//    immediately; after release s_ready=1.

Source files
------------

// File: rtl/matmul_operand_loader.sv
// Fills A then B from a row-major valid/ready element stream, then enables matmul for LATENCY cycles
// and holds the frozen result (c_valid) until the consumer acknowledges with c_ready.
module matmul_operand_loader #(
  parameter int R1      = 2,
  parameter int C1      = 2,
  parameter int R2      = 2,
  parameter int C2      = 2,
  parameter int W_A     = 8,
  parameter int W_B     = 8,
  parameter int W_IN    = (W_A > W_B) ? W_A : W_B,
  parameter int LATENCY = $clog2(C1) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [W_IN-1:0]                    s_data,
  input  logic                               s_last,
  output logic [R1-1:0][C1-1:0][W_A-1:0]     A,
  output logic [R2-1:0][C2-1:0][W_B-1:0]     B,
  output logic                               cen,
  output logic                               c_valid,
  input  logic                               c_ready,
  output logic                               frame_err
);

  localparam int NA   = R1 * C1;
  localparam int NB   = R2 * C2;
  localparam int NMAX = (NA > NB) ? NA : NB;
  localparam int IW   = $clog2(NMAX + 1);
  localparam int LW   = $clog2(LATENCY + 1);

  if (C1 != R2) begin : g_dim_chk
    $error("matmul_operand_loader: C1 must equal R2");
  end

  typedef enum logic [2:0] {LOAD_A, LOAD_B, DRAIN, COMPUTE, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [LW-1:0] lat_cnt;
  logic          beat;

  // Ready depends on state only, so upstream may hold s_valid on it combinationally.
  assign s_ready = ~rst & ((state == LOAD_A) | (state == LOAD_B) | (state == DRAIN));
  assign beat    = s_valid & s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      idx       <= '0;
      lat_cnt   <= '0;
      A         <= '0;
      B         <= '0;
      cen       <= 1'b0;
      c_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD_A: begin
          if (beat) begin
            if (s_last) begin
              // Premature end of frame: drop the partial A and restart.
              frame_err <= 1'b1;
              idx       <= '0;
            end else begin
              for (int r = 0; r < R1; r++) begin
                for (int c = 0; c < C1; c++) begin
                  if (idx == IW'(r * C1 + c)) A[r][c] <= s_data[W_A-1:0];
                end
              end
              if (idx == IW'(NA - 1)) begin
                idx   <= '0;
                state <= LOAD_B;
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end
        end
        LOAD_B: begin
          if (beat) begin
            for (int r = 0; r < R2; r++) begin
              for (int c = 0; c < C2; c++) begin
                if (idx == IW'(r * C2 + c)) B[r][c] <= s_data[W_B-1:0];
              end
            end
            if (idx == IW'(NB - 1)) begin
              idx <= '0;
              if (s_last) begin
                state   <= COMPUTE;
                lat_cnt <= '0;
                cen     <= 1'b1;
              end else begin
                // Frame is too long: swallow beats until its s_last shows up.
                frame_err <= 1'b1;
                state     <= DRAIN;
              end
            end else if (s_last) begin
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= LOAD_A;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (beat && s_last) begin
            idx   <= '0;
            state <= LOAD_A;
          end
        end
        COMPUTE: begin
          if (lat_cnt == LW'(LATENCY - 1)) begin
            cen     <= 1'b0;
            c_valid <= 1'b1;
            state   <= DONE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        DONE: begin
          if (c_ready) begin
            c_valid <= 1'b0;
            idx     <= '0;
            state   <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed and randomized frames for matmul_operand_loader, checked against a plain
// arithmetic model of the operand matrices, their product and the cen/c_valid timing.
module tb_matmul_operand_loader;
  localparam int R1 = 2, C1 = 2, R2 = 2, C2 = 2, W_A = 8, W_B = 8, W_IN = 8;
  localparam int LAT = 2;
  localparam int NA = R1 * C1, NB = R2 * C2;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, s_last, cen, c_valid, c_ready, frame_err;
  logic [W_IN-1:0] s_data;
  logic [R1-1:0][C1-1:0][W_A-1:0] A;
  logic [R2-1:0][C2-1:0][W_B-1:0] B;

  int checks = 0;
  int errors = 0;
  int cen_cycles;
  int err_pulses;
  logic [W_A-1:0] va [NA];
  logic [W_B-1:0] vb [NB];

  always #5 clk = ~clk;

  matmul_operand_loader #(
    .R1(R1), .C1(C1), .R2(R2), .C2(C2), .W_A(W_A), .W_B(W_B), .W_IN(W_IN), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .A(A), .B(B), .cen(cen), .c_valid(c_valid), .c_ready(c_ready),
    .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cen) cen_cycles++;
    if (frame_err) err_pulses++;
  endtask

  task automatic beat(input logic [W_IN-1:0] d, input logic last, input int gap);
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int n = 0; n < 50; n++) begin
      if (s_ready) begin
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    errors++;
    $error("FAIL beat_timeout observed=no_ready expected=ready");
  endtask

  function automatic int ref_c(input int i, input int j);
    int s = 0;
    for (int k = 0; k < C1; k++)
      s += int'($signed(va[i*C1+k])) * int'($signed(vb[k*C2+j]));
    return s;
  endfunction

  function automatic int dut_c(input int i, input int j);
    int s = 0;
    for (int k = 0; k < C1; k++)
      s += int'($signed(A[i][k])) * int'($signed(B[k][j]));
    return s;
  endfunction

  // gap < 0 selects a random 0..2 cycle gap before each beat.
  task automatic send_frame(input int gap);
    cen_cycles = 0;
    err_pulses = 0;
    for (int k = 0; k < NA; k++) beat(W_IN'(va[k]), 1'b0, gap < 0 ? $urandom_range(2) : gap);
    for (int k = 0; k < NB; k++) beat(W_IN'(vb[k]), k == NB - 1, gap < 0 ? $urandom_range(2) : gap);
  endtask

  task automatic check_result(input string tag, input int hold);
    int waited = 0;
    while (!c_valid && waited < 20) begin
      chk({tag, "_sready_busy"}, 64'(s_ready), 64'd0);
      tick();
      waited++;
    end
    chk({tag, "_cvalid_delay"}, 64'(waited), 64'(LAT));
    chk({tag, "_cen_cycles"}, 64'(cen_cycles), 64'(LAT));
    chk({tag, "_frame_err"}, 64'(err_pulses), 64'd0);
    for (int r = 0; r < R1; r++)
      for (int c = 0; c < C1; c++) chk({tag, "_A"}, 64'(A[r][c]), 64'(va[r*C1+c]));
    for (int r = 0; r < R2; r++)
      for (int c = 0; c < C2; c++) chk({tag, "_B"}, 64'(B[r][c]), 64'(vb[r*C2+c]));
    for (int i = 0; i < R1; i++)
      for (int j = 0; j < C2; j++) chk({tag, "_C"}, 64'(dut_c(i, j)), 64'(ref_c(i, j)));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_cvalid"}, 64'(c_valid), 64'd1);
      chk({tag, "_hold_cen"}, 64'(cen), 64'd0);
      chk({tag, "_hold_sready"}, 64'(s_ready), 64'd0);
      for (int i = 0; i < R1; i++)
        for (int j = 0; j < C2; j++) chk({tag, "_hold_C"}, 64'(dut_c(i, j)), 64'(ref_c(i, j)));
    end
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    chk({tag, "_cvalid_clear"}, 64'(c_valid), 64'd0);
    chk({tag, "_sready_back"}, 64'(s_ready), 64'd1);
  endtask

  task automatic set_seq();
    for (int k = 0; k < NA; k++) va[k] = W_A'(k + 1);
    for (int k = 0; k < NB; k++) vb[k] = W_B'(NA + k + 1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; c_ready = 1'b0;
    cen_cycles = 0; err_pulses = 0;
    repeat (2) tick();
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_B", 64'(B), 64'd0);
    chk("rst_cen", 64'(cen), 64'd0);
    chk("rst_cvalid", 64'(c_valid), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_sready", 64'(s_ready), 64'd1);

    // 1..8 gives C = [[19,22],[43,50]].
    set_seq();
    send_frame(0);
    chk("t1_C00_const", 64'(ref_c(0, 0)), 64'd19);
    check_result("t1", 0);

    // Signed corners, back-to-back then with s_valid toggling.
    for (int k = 0; k < NA; k++) va[k] = 8'hFF;
    for (int k = 0; k < NB; k++) vb[k] = 8'h80;
    send_frame(0);
    chk("t2_C11", 64'(dut_c(1, 1)), 64'd256);
    check_result("t2a", 0);
    send_frame(1);
    check_result("t2b", 0);

    // Consumer stalls five cycles in DONE.
    set_seq();
    send_frame(0);
    check_result("t3", 5);

    // s_last on the third beat aborts, then a clean frame.
    err_pulses = 0;
    beat(8'd1, 1'b0, 0);
    beat(8'd2, 1'b0, 0);
    beat(8'd3, 1'b1, 0);
    chk("t4_err_pulse", 64'(frame_err), 64'd1);
    tick();
    chk("t4_err_one_cycle", 64'(frame_err), 64'd0);
    chk("t4_err_count", 64'(err_pulses), 64'd1);
    send_frame(0);
    check_result("t4", 0);

    // Overlong frame: error after 8 beats, drain until s_last.
    cen_cycles = 0;
    err_pulses = 0;
    for (int k = 0; k < NA + NB; k++) beat(8'(k + 20), 1'b0, 0);
    chk("t5_err_pulse", 64'(frame_err), 64'd1);
    beat(8'd40, 1'b0, 1);
    beat(8'd41, 1'b0, 0);
    beat(8'd42, 1'b1, 2);
    tick();
    chk("t5_err_count", 64'(err_pulses), 64'd1);
    chk("t5_cen_never", 64'(cen_cycles), 64'd0);
    chk("t5_sready", 64'(s_ready), 64'd1);
    chk("t5_cvalid", 64'(c_valid), 64'd0);
    set_seq();
    send_frame(0);
    check_result("t5_after", 0);

    // Randomized frames with gaps and stalls.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NA; k++) va[k] = W_A'($urandom);
      for (int k = 0; k < NB; k++) vb[k] = W_B'($urandom);
      send_frame(-1);
      check_result("rand", $urandom_range(3));
    end

    // Reset in the first COMPUTE cycle.
    set_seq();
    send_frame(0);
    chk("t6_cen_before", 64'(cen), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_cen", 64'(cen), 64'd0);
    chk("t6_A", 64'(A), 64'd0);
    chk("t6_B", 64'(B), 64'd0);
    chk("t6_cvalid", 64'(c_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_sready", 64'(s_ready), 64'd1);
    tick();
    chk("t6_cen_after", 64'(cen), 64'd0);
    send_frame(0);
    check_result("t6_after", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
